// File: rtl/apb_pkg.sv
// Shared APB types: master and completer state encodings plus bus alignment.
package apb_pkg;

  localparam int APB_ALIGN_BITS = 2;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } slave_state_t;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between one master and one completer.
interface apb_slave_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Handshake: a transfer opens with pselx=1/penable=0 (SETUP) for one cycle,
  // then holds pselx=1/penable=1 (ACCESS) until the completer returns pready=1;
  // prdata and pslverr are meaningful only in that pready cycle.
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile.sv
// Register bank: entry 0 is a constant ID, entries 1..NUM_REGS-1 are storage.
module apb_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA0B0_0001,
  localparam int                   IW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IW-1:0]         ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1:NUM_REGS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && widx != '0) begin
      mem[widx] <= wdata;
    end
  end

  // Indices past NUM_REGS only occur for non-power-of-two banks; read them as 0.
  always_comb begin
    rdata = '0;
    if (ridx == '0)                           rdata = ID_VALUE;
    else if ({1'b0, ridx} < NUM_REGS[IW:0])   rdata = mem[ridx];
  end

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer: SETUP/ACCESS decode, fixed wait states, error decode, regfile.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA0B0_0001
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb_slave_regs_if.slave       bus,
  output slave_state_t          state_dbg
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = 4;

  slave_state_t          state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic                  err_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic                  setup;
  logic                  sel_wr;
  logic                  sel_err;
  logic [IW-1:0]         sel_idx;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  function automatic logic calc_err(logic [ADDR_WIDTH-1:0] a, logic wr);
    logic [IW-1:0] idx;
    logic          upper;
    idx   = a[APB_ALIGN_BITS +: IW];
    upper = |(a >> (APB_ALIGN_BITS + IW));
    return (a[APB_ALIGN_BITS-1:0] != '0) || upper ||
           ({1'b0, idx} >= NUM_REGS[IW:0]) || (wr && idx == '0);
  endfunction

  // With zero wait states the response is built straight from the SETUP inputs.
  always_comb begin
    setup   = bus.pselx && !bus.penable;
    sel_wr  = (state == S_IDLE) ? bus.pwrite : wr_q;
    sel_idx = (state == S_IDLE) ? bus.paddr[APB_ALIGN_BITS +: IW] : idx_q;
    sel_err = (state == S_IDLE) ? calc_err(bus.paddr, bus.pwrite) : err_q;
    we      = (state == S_READY) && bus.pselx && bus.penable && wr_q && !err_q;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      case (state)
        S_IDLE: begin
          if (setup) begin
            idx_q   <= sel_idx;
            wdata_q <= bus.pwdata;
            wr_q    <= bus.pwrite;
            err_q   <= sel_err;
            cnt     <= CW'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state     <= S_READY;
              pready_q  <= 1'b1;
              pslverr_q <= sel_err;
              prdata_q  <= (!sel_wr && !sel_err) ? rdata : '0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.pselx) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state     <= S_READY;
              pready_q  <= 1'b1;
              pslverr_q <= sel_err;
              prdata_q  <= (!sel_wr && !sel_err) ? rdata : '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (sel_idx),
    .rdata (rdata)
  );

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench: three completers with 0, 3 and 2 wait states on one clock.
module tb_apb_slave_regs;
  import apb_pkg::*;

  logic        pclk;
  logic        rst  [3];
  logic        psel [3];
  logic        pen  [3];
  logic        pwr  [3];
  logic [31:0] padr [3];
  logic [31:0] pwd  [3];
  logic [31:0] rd   [3];
  logic        rdy  [3];
  logic        err  [3];
  slave_state_t st  [3];

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();
    assign ifc.pselx   = psel[g];
    assign ifc.penable = pen[g];
    assign ifc.pwrite  = pwr[g];
    assign ifc.paddr   = padr[g];
    assign ifc.pwdata  = pwd[g];
    assign rd[g]  = ifc.prdata;
    assign rdy[g] = ifc.pready;
    assign err[g] = ifc.pslverr;

    apb_slave_regs #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .NUM_REGS    (16),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 2),
      .ID_VALUE    (32'hA0B0_0001)
    ) dut (
      .pclk      (pclk),
      .preset    (rst[g]),
      .bus       (ifc.slave),
      .state_dbg (st[g])
    );
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one full transfer with latency, response and single-cycle pulse checks
  task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int ws, input bit exp_err, input logic [31:0] exp_rd,
                      input string tag);
    int cyc;
    @(negedge pclk);
    psel[i] = 1'b1; pen[i] = 1'b0; pwr[i] = wr; padr[i] = a; pwd[i] = d;
    @(negedge pclk);
    pen[i] = 1'b1; pwd[i] = ~d;
    cyc = 1;
    while (!rdy[i] && cyc <= ws + 4) begin
      @(negedge pclk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, ws + 1);
    check({tag, "_err"}, 32'(err[i]), 32'(exp_err));
    check({tag, "_rdata"}, rd[i], exp_rd);
    @(negedge pclk);
    check({tag, "_pulse"}, 32'(rdy[i]), 32'd0);
    psel[i] = 1'b0; pen[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit seen;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; psel[i] = 1'b0; pen[i] = 1'b0; pwr[i] = 1'b0;
      padr[i] = '0; pwd[i] = '0;
    end
    repeat (3) @(negedge pclk);
    check("rst_pready", 32'(rdy[0]), 32'd0);
    check("rst_pslverr", 32'(err[0]), 32'd0);
    check("rst_prdata", rd[0], 32'd0);
    check("rst_state", 32'(st[0]), 32'(S_IDLE));
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge pclk);

    // zero wait states: write then read back
    xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, "ws0_wr4");
    xfer(0, 1'b0, 32'h4, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, "ws0_rd4");

    // three wait states: ID register and read-only write
    xfer(1, 1'b0, 32'h0, 32'h0, 3, 1'b0, 32'hA0B0_0001, "ws3_rd0");
    xfer(1, 1'b1, 32'h0, 32'h1234, 3, 1'b1, 32'h0, "ws3_wr0");
    xfer(1, 1'b0, 32'h0, 32'h0, 3, 1'b0, 32'hA0B0_0001, "ws3_rd0b");

    // misaligned and out-of-range accesses
    xfer(0, 1'b0, 32'h6, 32'h0, 0, 1'b1, 32'h0, "ws0_rd6");
    xfer(0, 1'b0, 32'h40, 32'h0, 0, 1'b1, 32'h0, "ws0_rd40");
    xfer(0, 1'b1, 32'h44, 32'h11, 0, 1'b1, 32'h0, "ws0_wr44");
    xfer(0, 1'b1, 32'h5, 32'h22, 0, 1'b1, 32'h0, "ws0_wr5");
    xfer(0, 1'b0, 32'h4, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, "ws0_rd4b");

    // two wait states: abort by dropping pselx after one ACCESS cycle
    @(negedge pclk);
    psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1; padr[2] = 32'h8; pwd[2] = 32'h55;
    @(negedge pclk);
    pen[2] = 1'b1;
    check("abort_state_wait", 32'(st[2]), 32'(S_WAIT));
    @(negedge pclk);
    psel[2] = 1'b0; pen[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rdy[2]) seen = 1'b1;
      @(negedge pclk);
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    check("abort_state_idle", 32'(st[2]), 32'(S_IDLE));
    xfer(2, 1'b0, 32'h8, 32'h0, 2, 1'b0, 32'h0, "ws2_rd8");
    xfer(2, 1'b1, 32'h8, 32'h77, 2, 1'b0, 32'h0, "ws2_wr8");
    xfer(2, 1'b0, 32'h8, 32'h0, 2, 1'b0, 32'h77, "ws2_rd8b");

    // reset during a wait state of a write
    @(negedge pclk);
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1; padr[1] = 32'hC; pwd[1] = 32'hFF;
    @(negedge pclk);
    pen[1] = 1'b1;
    check("rstw_state_wait", 32'(st[1]), 32'(S_WAIT));
    #1 rst[1] = 1'b1;
    #1;
    check("rstw_pready", 32'(rdy[1]), 32'd0);
    check("rstw_prdata", rd[1], 32'd0);
    check("rstw_pslverr", 32'(err[1]), 32'd0);
    check("rstw_state", 32'(st[1]), 32'(S_IDLE));
    @(negedge pclk);
    rst[1] = 1'b0; psel[1] = 1'b0; pen[1] = 1'b0;
    xfer(1, 1'b0, 32'hC, 32'h0, 3, 1'b0, 32'h0, "ws3_rdC");

    // reset while pready is high must clear it without a clock edge
    @(negedge pclk);
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b0; padr[0] = 32'h4;
    @(negedge pclk);
    pen[0] = 1'b1;
    check("rstr_pready_pre", 32'(rdy[0]), 32'd1);
    check("rstr_prdata_pre", rd[0], 32'hDEAD_BEEF);
    #1 rst[0] = 1'b1;
    #1;
    check("rstr_pready", 32'(rdy[0]), 32'd0);
    check("rstr_prdata", rd[0], 32'd0);
    @(negedge pclk);
    rst[0] = 1'b0; psel[0] = 1'b0; pen[0] = 1'b0;
    xfer(0, 1'b0, 32'h4, 32'h0, 0, 1'b0, 32'h0, "ws0_rd4_after_rst");

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
